demux16_deserializer: RTL

//  Serial-to-parallel counterpart of the 16:1 bit-select mux path. Takes one bit
//  per accepted cycle, steers it through a 1:16 demux into bit position sel_idx of
//  a working word, and presents the completed 16-bit word with a valid/ready

---
 rtl/demux16_deserializer_pkg.sv | 29 ++
 rtl/demux16_deserializer_if.sv | 24 ++
 rtl/demux16_deserializer_demux1x16.sv | 22 ++
 rtl/demux16_deserializer.sv | 105 ++++++++++
 4 files changed

// File: rtl/demux16_deserializer_pkg.sv
// Shared types and constants for the 16-bit serial-to-parallel deserializer.
// Build option: DEMUX_MSB_FIRST_EN places the first serial bit in word bit 15
// instead of word bit 0.
package demux_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [SEL_W-1:0] sel_t;

  // Output holding register occupancy; FULL is exactly out_valid=1.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam sel_t SEL_LAST = sel_t'(WIDTH - 1);

  // Map the logical bit count to the physical bit position in the word.
  function automatic sel_t bit_pos(input sel_t idx);
`ifdef DEMUX_MSB_FIRST_EN
    return SEL_LAST - idx;
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/demux16_deserializer_if.sv
// Handshake/data bundle between the serial source / word consumer and the
// deserializer. master = testbench or surrounding logic, slave = deserializer.
interface demux16_deserializer_if;

  logic             in_bit;
  logic             in_valid;
  logic             clear;
  logic             out_ready;
  demux_pkg::word_t out16;
  logic             out_valid;
  demux_pkg::sel_t  sel_idx;
  logic             overrun;

  modport master (
    output in_bit, in_valid, clear, out_ready,
    input  out16, out_valid, sel_idx, overrun
  );

  modport slave (
    input  in_bit, in_valid, clear, out_ready,
    output out16, out_valid, sel_idx, overrun
  );

endinterface

// File: rtl/demux16_deserializer_demux1x16.sv
// Combinational 1:16 demux: routes the data bit onto the selected output lane
// when enabled; every other lane is 0. With in=1 the result is a one-hot strobe.
module demux1x16
  import demux_pkg::*;
(
  input  sel_t  sel4,
  input  logic  in,
  input  logic  en,
  output word_t out16
);

  // Decode the select into a single active lane carrying the data bit.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment so
    // no path leaves it unassigned, which would infer a latch.
    out16 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out16[i] = en & in & (sel4 == sel_t'(i));
    end
  end

endmodule

// File: rtl/demux16_deserializer.sv
// 16-bit serial-to-parallel deserializer with a one-word output holding
// register and valid/ready handshake. Collection never stalls: the working
// word keeps filling while the holding register waits for the consumer, and a
// word completed while the register is still occupied and not being drained is
// dropped and flagged in the sticky overrun bit.
// Build option: DEMUX_MSB_FIRST_EN (see demux_pkg::bit_pos) reverses placement.
module demux16_deserializer
  import demux_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  demux16_deserializer_if.slave  bus
);

  word_t      work_q, work_d;
  word_t      out_q, out_d;
  sel_t       sel_q, sel_d;
  out_state_t state_q, state_d;
  logic       overrun_q, overrun_d;

  word_t      strobe;
  word_t      work_merged;
  logic       completion;

  demux1x16 u_demux (
    .sel4  (bit_pos(sel_q)),
    .in    (bus.in_bit),
    .en    (bus.in_valid),
    .out16 (strobe)
  );

  // Each position is written once per word and work restarts at zero, so
  // OR-ing in the routed bit is a full write of that position.
  assign work_merged = work_q | strobe;
  assign completion  = bus.in_valid & (sel_q == SEL_LAST);

  // Next-state: bit collection, holding-register occupancy and overrun flag.
  always_comb begin
    work_d    = work_q;
    out_d     = out_q;
    sel_d     = sel_q;
    state_d   = state_q;
    overrun_d = overrun_q;

    if (bus.in_valid) begin
      sel_d  = sel_q + 1'b1;
      work_d = completion ? '0 : work_merged;
    end

    case (state_q)
      EMPTY: begin
        if (completion) begin
          out_d   = work_merged;
          state_d = FULL;
        end
      end
      FULL: begin
        if (completion) begin
          if (bus.out_ready) begin
            out_d = work_merged;
          end else begin
            overrun_d = 1'b1;
          end
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over any data/handshake activity on the same edge.
    if (bus.clear) begin
      work_d    = '0;
      out_d     = '0;
      sel_d     = '0;
      state_d   = EMPTY;
      overrun_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      work_q    <= '0;
      out_q     <= '0;
      sel_q     <= '0;
      state_q   <= EMPTY;
      overrun_q <= 1'b0;
    end else begin
      work_q    <= work_d;
      out_q     <= out_d;
      sel_q     <= sel_d;
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out16     = out_q;
  assign bus.out_valid = (state_q == FULL);
  assign bus.sel_idx   = sel_q;
  assign bus.overrun   = overrun_q;

endmodule
